// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, tagged-sample type and helpers for the Sobel edge stage.
package sobel_pkg;
    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 11;
    localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

    typedef struct packed {
        logic             blank;
        logic [PIX_W-1:0] pix;
    } tpix_t;

    function automatic logic [GRAD_W-1:0] abs_g(input logic [GRAD_W-1:0] v);
        return v[GRAD_W-1] ? -v : v;
    endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: enable-gated delay line of tagged samples, one entry per accepted sample.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 400
) (
    input  logic  clock,
    input  logic  en,
    input  tpix_t d,
    output tpix_t q
);
    tpix_t [DEPTH-1:0] mem_q;

    always_ff @(posedge clock) begin
        if (en) mem_q <= {mem_q[DEPTH-2:0], d};
    end

    assign q = mem_q[DEPTH-1];
endmodule

// File: rtl/sobel_edge_window.sv
// sobel_edge_window: streaming 3x3 Sobel magnitude with saturation, threshold and blanking-aware borders.
module sobel_edge_window
    import sobel_pkg::*;
#(
    parameter int               LINE_LEN = 400,
    parameter logic [MAG_W-1:0] THRESH   = 11'd128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] din,
    input  logic             blanking_in,
    input  logic             validin,
    output logic [PIX_W-1:0] dout,
    output logic             edge_out,
    output logic             blanking_out,
    output logic             validout
);
    localparam int PRIME = 2*LINE_LEN + 2;
    localparam int CNT_W = $clog2(PRIME + 1);

    tpix_t              s_in, tap0, tap1;
    tpix_t [2:0][2:0]   win_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               win_v_q, v1_q, blank1_q, ctr1_q;
    logic [GRAD_W-1:0]  gx_d, gy_d, gx_q, gy_q;
    logic               any_blank_d, ok_d;
    logic [MAG_W-1:0]   mag_d;
    logic [PIX_W-1:0]   dout_d, dout_q;
    logic               edge_q, blank_q, valid_q;

    assign s_in = '{blank: blanking_in, pix: din};

    sobel_line_buffer #(.DEPTH(LINE_LEN)) u_lb0 (.clock(clock), .en(validin), .d(s_in), .q(tap0));
    sobel_line_buffer #(.DEPTH(LINE_LEN)) u_lb1 (.clock(clock), .en(validin), .d(tap0), .q(tap1));

    // win_v_q marks a window whose oldest sample was accepted after reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            win_q   <= '0;
            win_v_q <= 1'b0;
        end else if (validin) begin
            if (cnt_q != CNT_W'(PRIME)) cnt_q <= cnt_q + 1'b1;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 2; c++)
                    win_q[r][c] <= win_q[r][c+1];
            win_q[0][2] <= tap1;
            win_q[1][2] <= tap0;
            win_q[2][2] <= s_in;
            win_v_q     <= (cnt_q == CNT_W'(PRIME));
        end
    end

    always_comb begin
        gx_d = (GRAD_W'(win_q[0][2].pix) + (GRAD_W'(win_q[1][2].pix) << 1) + GRAD_W'(win_q[2][2].pix))
             - (GRAD_W'(win_q[0][0].pix) + (GRAD_W'(win_q[1][0].pix) << 1) + GRAD_W'(win_q[2][0].pix));
        gy_d = (GRAD_W'(win_q[2][0].pix) + (GRAD_W'(win_q[2][1].pix) << 1) + GRAD_W'(win_q[2][2].pix))
             - (GRAD_W'(win_q[0][0].pix) + (GRAD_W'(win_q[0][1].pix) << 1) + GRAD_W'(win_q[0][2].pix));
        any_blank_d = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                any_blank_d = any_blank_d | win_q[r][c].blank;
    end

    always_comb begin
        mag_d  = abs_g(gx_q) + abs_g(gy_q);
        ok_d   = v1_q & ~blank1_q;
        dout_d = !ok_d ? '0 : (mag_d > MAG_W'(SAT_MAX)) ? SAT_MAX : mag_d[PIX_W-1:0];
    end

    // Stalls freeze every stage; only validout drops for the stalled cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gx_q     <= '0;
            gy_q     <= '0;
            v1_q     <= 1'b0;
            blank1_q <= 1'b0;
            ctr1_q   <= 1'b0;
            dout_q   <= '0;
            edge_q   <= 1'b0;
            blank_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else if (validin) begin
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            v1_q     <= win_v_q;
            blank1_q <= any_blank_d;
            ctr1_q   <= win_q[1][1].blank;
            dout_q   <= dout_d;
            edge_q   <= ok_d & (mag_d >= THRESH);
            blank_q  <= ctr1_q;
            valid_q  <= v1_q;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign dout         = dout_q;
    assign edge_out     = edge_q;
    assign blanking_out = blank_q;
    assign validout     = valid_q;
endmodule
